// File: rtl/dram_arb_pkg.sv
// Shared constants and helpers for the DRAM read arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: read latency, index/tag width helpers, flattened-bus slice macro.
`ifndef DRAM_ARB_SL
`define DRAM_ARB_SL(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package dram_arb_pkg;

   // Grant to response, in clock cycles.
   localparam int RD_LAT = 3;

   // Requester index width; never below one bit so NREQ=1 still has a legal vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Tag = {valid, index}.
   function automatic int tag_w(input int n);
      return idx_w(n) + 1;
   endfunction

endpackage

// File: rtl/special_dram_rd_arbiter_rr_pick2.sv
// Round-robin two-winner selector: scans req from ptr upward (mod NREQ).
// Latency: purely combinational. Backpressure: none, pure function of req/ptr.
// Ports: req (NREQ), ptr -> idx_a/vld_a (first hit), idx_b/vld_b (second hit).
module rr_pick2
#(
   parameter int NREQ = 4,
   parameter int IW   = 2
)
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx_a,
   output logic            vld_a,
   output logic [IW-1:0]   idx_b,
   output logic            vld_b
);

   always_comb begin
      int j;
      j     = 0;
      idx_a = '0;
      vld_a = 1'b0;
      idx_b = '0;
      vld_b = 1'b0;
      // Each index is visited once per scan, so A and B can never coincide.
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (req[j]) begin
            if (!vld_a) begin
               vld_a = 1'b1;
               idx_a = IW'(j);
            end else if (!vld_b) begin
               vld_b = 1'b1;
               idx_b = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/special_dram_rd_arbiter.sv
// Shares the two DRAM read ports among NREQ requesters, up to two grants per cycle.
// Latency: grant (req_ready) to rsp_valid is 3 cycles; write port is a combinational pass-through.
// Backpressure: requesters hold valid/addr until req_ready; responses cannot be stalled.
// Ports: clk, rst_n (sync, active-low); req_valid/req_addr/req_ready; rsp_valid/rsp_data;
//        wr_req/wr_addr/wr_data -> ram_wr_ena/ram_wr_addr/ram_data; ram_rd_ena_x/ram_rd_addr_x
//        and ram_q_x/ram_dval_x per port A/B.
// Optional: define DRAM_ARB_FWD_EN to return same-cycle write data on a read/write address hit.
module special_dram_rd_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = 16,
   parameter int DW   = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [NREQ*DW-1:0] rsp_data,
   input  logic              wr_req,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DW-1:0]      wr_data,
   output logic              ram_wr_ena,
   output logic [AW-1:0]      ram_wr_addr,
   output logic [DW-1:0]      ram_data,
   output logic              ram_rd_ena_a,
   output logic [AW-1:0]      ram_rd_addr_a,
   output logic              ram_rd_ena_b,
   output logic [AW-1:0]      ram_rd_addr_b,
   input  logic [DW-1:0]      ram_q_a,
   input  logic              ram_dval_a,
   input  logic [DW-1:0]      ram_q_b,
   input  logic              ram_dval_b
);

   localparam int IW   = idx_w(NREQ);
   localparam int TAGW = tag_w(NREQ);

   logic [IW-1:0]   ptr;
   logic [IW-1:0]   idx_a, idx_b;
   logic            vld_a, vld_b;
   logic [TAGW-1:0] tag1_a, tag1_b, tag2_a, tag2_b;
   logic [DW-1:0]   ret_a, ret_b;

   assign ram_wr_ena  = wr_req;
   assign ram_wr_addr = wr_addr;
   assign ram_data    = wr_data;

   rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .idx_a (idx_a),
      .vld_a (vld_a),
      .idx_b (idx_b),
      .vld_b (vld_b)
   );

   // Grants are gated by reset so nothing handshakes while the pipeline is being cleared.
   always_comb begin
      req_ready = '0;
      if (rst_n) begin
         if (vld_a) req_ready[idx_a] = 1'b1;
         if (vld_b) req_ready[idx_b] = 1'b1;
      end
   end

   function automatic logic [IW-1:0] step(input logic [IW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

`ifdef DRAM_ARB_FWD_EN
   // The compare uses the registered read address, i.e. the cycle the RAM samples it;
   // the hit and write data then travel alongside tag stage 2.
   logic          fwd_a, fwd_b;
   logic [DW-1:0] fwd_dat_a, fwd_dat_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_a     <= 1'b0;
         fwd_b     <= 1'b0;
         fwd_dat_a <= '0;
         fwd_dat_b <= '0;
      end else begin
         fwd_a     <= ram_rd_ena_a && wr_req && (wr_addr == ram_rd_addr_a);
         fwd_b     <= ram_rd_ena_b && wr_req && (wr_addr == ram_rd_addr_b);
         fwd_dat_a <= wr_data;
         fwd_dat_b <= wr_data;
      end
   end

   assign ret_a = fwd_a ? fwd_dat_a : ram_q_a;
   assign ret_b = fwd_b ? fwd_dat_b : ram_q_b;
`else
   assign ret_a = ram_q_a;
   assign ret_b = ram_q_b;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr           <= '0;
         ram_rd_ena_a  <= 1'b0;
         ram_rd_addr_a <= '0;
         ram_rd_ena_b  <= 1'b0;
         ram_rd_addr_b <= '0;
         tag1_a        <= '0;
         tag1_b        <= '0;
         tag2_a        <= '0;
         tag2_b        <= '0;
         rsp_valid     <= '0;
         rsp_data      <= '0;
      end else begin
         // Resume the scan just past the last requester served this cycle.
         if (vld_b)      ptr <= step(idx_b);
         else if (vld_a) ptr <= step(idx_a);

         ram_rd_ena_a <= vld_a;
         ram_rd_ena_b <= vld_b;
         if (vld_a) ram_rd_addr_a <= `DRAM_ARB_SL(req_addr, idx_a, AW);
         if (vld_b) ram_rd_addr_b <= `DRAM_ARB_SL(req_addr, idx_b, AW);

         tag1_a <= {vld_a, idx_a};
         tag1_b <= {vld_b, idx_b};
         tag2_a <= tag1_a;
         tag2_b <= tag1_b;

         // Reads issued before a reset return with an invalid tag and are dropped here.
         rsp_valid <= '0;
         for (int i = 0; i < NREQ; i++) begin
            if (tag2_a[TAGW-1] && ram_dval_a && tag2_a[IW-1:0] == IW'(i)) begin
               rsp_valid[i]                <= 1'b1;
               `DRAM_ARB_SL(rsp_data, i, DW) <= ret_a;
            end
            if (tag2_b[TAGW-1] && ram_dval_b && tag2_b[IW-1:0] == IW'(i)) begin
               rsp_valid[i]                <= 1'b1;
               `DRAM_ARB_SL(rsp_data, i, DW) <= ret_b;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Sticky RAM-fault indicator: a valid tag came back without dval.
   logic err_q;
   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_q | (tag2_a[TAGW-1] & ~ram_dval_a) | (tag2_b[TAGW-1] & ~ram_dval_b);
   end
`endif

endmodule
